// File: rtl/serial_subtractor_if.sv
// Start/done handshake and operand/result bundle for serial_subtractor.
// SERIAL_SUB_BORROW_IN_EN adds the b_in borrow-in line to the bundle.
interface serial_subtractor_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
`ifdef SERIAL_SUB_BORROW_IN_EN
   logic             b_in;
`endif
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             b_out;
   logic             ovf;

`ifdef SERIAL_SUB_BORROW_IN_EN
   modport master (
      output start, a, b, b_in,
      input  busy, done, diff, b_out, ovf
   );

   modport slave (
      input  start, a, b, b_in,
      output busy, done, diff, b_out, ovf
   );
`else
   modport master (
      output start, a, b,
      input  busy, done, diff, b_out, ovf
   );

   modport slave (
      input  start, a, b,
      output busy, done, diff, b_out, ovf
   );
`endif
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one full-subtractor cell plus a borrow flop.
// SERIAL_SUB_BORROW_IN_EN: initial borrow comes from b_in instead of 0.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   serial_subtractor_if.slave   bus
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   function automatic logic fs_diff(input logic ai, input logic bi, input logic br);
      return ai ^ bi ^ br;
   endfunction

   function automatic logic fs_borrow(input logic ai, input logic bi, input logic br);
      return (~ai & bi) | (~ai & br) | (bi & br);
   endfunction

   // Two's-complement overflow of a - b: operands differ in sign and result sign flips.
   function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic d_msb);
      return (a_msb != b_msb) && (d_msb != a_msb);
   endfunction

   state_t           state_r;
   state_t           next_state_s;

   logic [WIDTH-1:0] a_sr_r;
   logic [WIDTH-1:0] b_sr_r;
   logic [WIDTH-1:0] d_sr_r;
   logic             borrow_r;
   logic [CW-1:0]    cnt_r;
   logic             a_msb_r;
   logic             b_msb_r;

   logic [WIDTH-1:0] diff_r;
   logic             b_out_r;
   logic             ovf_r;
   logic             busy_r;
   logic             done_r;

   logic             accept_s;
   logic             shift_en_s;
   logic             last_bit_s;
   logic             bit_diff_s;
   logic             bit_borrow_s;
   logic             borrow_init_s;

`ifdef SERIAL_SUB_BORROW_IN_EN
   assign borrow_init_s = bus.b_in;
`else
   assign borrow_init_s = 1'b0;
`endif

   assign bit_diff_s   = fs_diff(a_sr_r[0], b_sr_r[0], borrow_r);
   assign bit_borrow_s = fs_borrow(a_sr_r[0], b_sr_r[0], borrow_r);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state logic; DONE may accept a new start directly.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (bus.start) begin
               next_state_s = ST_SHIFT;
            end else begin
               next_state_s = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            if (cnt_r == LAST_CNT) begin
               next_state_s = ST_DONE;
            end else begin
               next_state_s = ST_SHIFT;
            end
         end
         ST_DONE: begin
            if (bus.start) begin
               next_state_s = ST_SHIFT;
            end else begin
               next_state_s = ST_IDLE;
            end
         end
         default: begin
            next_state_s = ST_IDLE;
         end
      endcase
   end

   // Control decode: operand acceptance, shift enable and last-bit strobe.
   always_comb begin
      accept_s   = 1'b0;
      shift_en_s = 1'b0;
      last_bit_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            accept_s = bus.start;
         end
         ST_SHIFT: begin
            shift_en_s = 1'b1;
            if (cnt_r == LAST_CNT) begin
               last_bit_s = 1'b1;
            end else begin
               last_bit_s = 1'b0;
            end
         end
         ST_DONE: begin
            accept_s = bus.start;
         end
         default: begin
            accept_s   = 1'b0;
            shift_en_s = 1'b0;
            last_bit_s = 1'b0;
         end
      endcase
   end

   // Operand/difference shift registers, borrow flop and bit counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_sr_r   <= '0;
         b_sr_r   <= '0;
         d_sr_r   <= '0;
         borrow_r <= 1'b0;
         cnt_r    <= '0;
         a_msb_r  <= 1'b0;
         b_msb_r  <= 1'b0;
      end else if (accept_s) begin
         a_sr_r   <= bus.a;
         b_sr_r   <= bus.b;
         borrow_r <= borrow_init_s;
         cnt_r    <= '0;
         a_msb_r  <= bus.a[WIDTH-1];
         b_msb_r  <= bus.b[WIDTH-1];
      end else if (shift_en_s) begin
         a_sr_r   <= a_sr_r >> 1;
         b_sr_r   <= b_sr_r >> 1;
         d_sr_r   <= {bit_diff_s, d_sr_r[WIDTH-1:1]};
         borrow_r <= bit_borrow_s;
         cnt_r    <= cnt_r + CW'(1);
      end
   end

   // Result registers: loaded only on the edge that enters DONE, held otherwise.
   always_ff @(posedge clk) begin
      if (rst) begin
         diff_r  <= '0;
         b_out_r <= 1'b0;
         ovf_r   <= 1'b0;
      end else if (last_bit_s) begin
         diff_r  <= {bit_diff_s, d_sr_r[WIDTH-1:1]};
         b_out_r <= bit_borrow_s;
         ovf_r   <= sub_ovf(a_msb_r, b_msb_r, bit_diff_s);
      end
   end

   // Handshake flags registered from the next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_r <= 1'b0;
         done_r <= 1'b0;
      end else begin
         busy_r <= (next_state_s == ST_SHIFT);
         done_r <= (next_state_s == ST_DONE);
      end
   end

   assign bus.busy  = busy_r;
   assign bus.done  = done_r;
   assign bus.diff  = diff_r;
   assign bus.b_out = b_out_r;
   assign bus.ovf   = ovf_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: cycle model from plain arithmetic
// plus directed vectors with hand-computed results.
module tb_serial_subtractor;
   localparam int W = 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   serial_subtractor_if #(.WIDTH(W)) bus();

   serial_subtractor #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: {ovf, borrow, diff} of x - y - bin from integer arithmetic.
   function automatic logic [W+1:0] ref_sub(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic bin);
      int ux, uy, ur, sx, sy, sr;
      logic [W-1:0] d;
      logic bo, ov;
      ux = int'(x);
      uy = int'(y);
      ur = ux - uy - int'(bin);
      d  = ur[W-1:0];
      bo = (ur < 0);
      sx = x[W-1] ? ux - (1 << W) : ux;
      sy = y[W-1] ? uy - (1 << W) : uy;
      sr = sx - sy - int'(bin);
      ov = (sr < -(1 << (W-1))) || (sr > (1 << (W-1)) - 1);
      return {ov, bo, d};
   endfunction

   // Cycle model: accept -> W busy cycles -> one done cycle with results.
   int           m_left = 0;
   logic         m_valid = 1'b0;
   logic         m_busy, m_done, m_bout, m_ovf;
   logic [W-1:0] m_diff;
   logic [W+1:0] p_res;
   logic         m_bin;

`ifdef SERIAL_SUB_BORROW_IN_EN
   assign m_bin = bus.b_in;
`else
   assign m_bin = 1'b0;
`endif

   always @(posedge clk) begin
      if (rst) begin
         m_left  <= 0;
         m_busy  <= 1'b0;
         m_done  <= 1'b0;
         m_diff  <= '0;
         m_bout  <= 1'b0;
         m_ovf   <= 1'b0;
         m_valid <= 1'b1;
      end else if (m_left > 0) begin
         m_left <= m_left - 1;
         m_busy <= (m_left > 1);
         m_done <= (m_left == 1);
         if (m_left == 1) begin
            m_diff <= p_res[W-1:0];
            m_bout <= p_res[W];
            m_ovf  <= p_res[W+1];
         end
      end else begin
         m_done <= 1'b0;
         if (bus.start) begin
            m_left <= W;
            m_busy <= 1'b1;
            p_res  <= ref_sub(bus.a, bus.b, m_bin);
         end else begin
            m_busy <= 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         chk("cyc_busy",  32'(bus.busy),  32'(m_busy));
         chk("cyc_done",  32'(bus.done),  32'(m_done));
         chk("cyc_diff",  32'(bus.diff),  32'(m_diff));
         chk("cyc_b_out", 32'(bus.b_out), 32'(m_bout));
         chk("cyc_ovf",   32'(bus.ovf),   32'(m_ovf));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pulse start with the operands, then wait (bounded) for done.
   task automatic op(input logic [W-1:0] av, input logic [W-1:0] bv, output int lat);
      bus.a     = av;
      bus.b     = bv;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      lat = 1;
      while (bus.done !== 1'b1 && lat < 4 * W) begin
         tick();
         lat++;
      end
   endtask

   int lat, lat2, ndone;
   logic [W-1:0] diff_seen;

   initial begin
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
`ifdef SERIAL_SUB_BORROW_IN_EN
      bus.b_in  = 1'b0;
`endif
      tick();
      tick();
      rst = 1'b0;
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_diff", 32'(bus.diff), 32'd0);
      chk("rst_bout", 32'(bus.b_out), 32'd0);
      chk("rst_ovf",  32'(bus.ovf), 32'd0);

      // 0x35 - 0x12
      op(8'h35, 8'h12, lat);
      chk("t1_latency", 32'(lat), 32'd9);
      chk("t1_diff", 32'(bus.diff), 32'h23);
      chk("t1_bout", 32'(bus.b_out), 32'd0);
      chk("t1_ovf",  32'(bus.ovf), 32'd0);
      tick();

      // Unsigned underflow, then signed overflow.
      op(8'h00, 8'h01, lat);
      chk("t2_diff", 32'(bus.diff), 32'hFF);
      chk("t2_bout", 32'(bus.b_out), 32'd1);
      chk("t2_ovf",  32'(bus.ovf), 32'd0);
      tick();
      op(8'h80, 8'h01, lat);
      chk("t2b_diff", 32'(bus.diff), 32'h7F);
      chk("t2b_bout", 32'(bus.b_out), 32'd0);
      chk("t2b_ovf",  32'(bus.ovf), 32'd1);
      tick();
      op(8'h7F, 8'hFF, lat);
      chk("t2c_diff", 32'(bus.diff), 32'h80);
      chk("t2c_bout", 32'(bus.b_out), 32'd1);
      chk("t2c_ovf",  32'(bus.ovf), 32'd1);
      tick();

      // Starts while busy are ignored; operands changed after acceptance.
      bus.a = 8'h0F; bus.b = 8'h0F; bus.start = 1'b1;
      tick();
      bus.start = 1'b0; bus.a = 8'hAA; bus.b = 8'h01;
      tick();
      tick();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      tick();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      ndone = 0;
      diff_seen = 8'h5A;
      for (int i = 0; i < 12; i++) begin
         if (bus.done === 1'b1) begin
            ndone++;
            diff_seen = bus.diff;
         end
         tick();
      end
      chk("t3_ndone", 32'(ndone), 32'd1);
      chk("t3_diff", 32'(diff_seen), 32'h00);
      chk("t3_bout", 32'(bus.b_out), 32'd0);

      // start held through DONE: back-to-back operation.
      bus.a = 8'h10; bus.b = 8'h20; bus.start = 1'b1;
      tick();
      lat = 1;
      while (bus.done !== 1'b1 && lat < 4 * W) begin
         tick();
         lat++;
      end
      chk("t4_latency", 32'(lat), 32'd9);
      chk("t4_diff", 32'(bus.diff), 32'hF0);
      chk("t4_bout", 32'(bus.b_out), 32'd1);
      tick();
      bus.start = 1'b0;
      chk("t4_busy_again", 32'(bus.busy), 32'd1);
      lat2 = 1;
      while (bus.done !== 1'b1 && lat2 < 4 * W) begin
         tick();
         lat2++;
      end
      chk("t4_gap", 32'(lat2), 32'd9);
      chk("t4_diff2", 32'(bus.diff), 32'hF0);
      tick();

      // Reset in the 4th SHIFT cycle abandons the operation.
      bus.a = 8'h55; bus.b = 8'h11; bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      tick();
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t5_busy", 32'(bus.busy), 32'd0);
      chk("t5_done", 32'(bus.done), 32'd0);
      chk("t5_diff", 32'(bus.diff), 32'd0);
      ndone = 0;
      for (int i = 0; i < 12; i++) begin
         if (bus.done === 1'b1) ndone++;
         tick();
      end
      chk("t5_nodone", 32'(ndone), 32'd0);
      op(8'h09, 8'h04, lat);
      chk("t5_latency", 32'(lat), 32'd9);
      chk("t5_diff2", 32'(bus.diff), 32'h05);
      tick();

`ifdef SERIAL_SUB_BORROW_IN_EN
      bus.b_in = 1'b1;
      op(8'h10, 8'h05, lat);
      chk("t6_diff", 32'(bus.diff), 32'h0A);
      chk("t6_bout", 32'(bus.b_out), 32'd0);
      tick();
      op(8'h00, 8'h00, lat);
      chk("t6b_diff", 32'(bus.diff), 32'hFF);
      chk("t6b_bout", 32'(bus.b_out), 32'd1);
      bus.b_in = 1'b0;
      tick();
`endif

      tick();
      tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
